// File: rtl/id_pipe_stage_if.sv
// Fetch-side and execute-side signals of the decode stage, grouped as one bundle.
// The stage itself connects through the slave modport; its driver uses master.
interface id_pipe_stage_if #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STALL_CNT_W = 16
);
  // Fetch side
  logic                   in_valid;
  logic                   in_ready;
  logic [31:0]            ins;
  logic [31:0]            npc_i;
  logic                   flush;
  // Writeback port
  logic                   reg_write;
  logic [4:0]             write_reg;
  logic [DATA_W-1:0]      write_data;
  // Execute side
  logic                   out_valid;
  logic                   out_ready;
  logic [5:0]             op;
  logic [5:0]             func;
  logic [DATA_W-1:0]      data_a;
  logic [DATA_W-1:0]      data_b;
  logic [DATA_W-1:0]      imm;
  logic [25:0]            jpc;
  logic [4:0]             dst;
  logic                   if_reg_write;
  logic                   if_mem_read;
  logic                   if_mem_write;
  logic                   illegal;
  logic [31:0]            npc_o;
  logic [STALL_CNT_W-1:0] stall_cnt;

  modport master (
    output in_valid, ins, npc_i, flush, reg_write, write_reg, write_data, out_ready,
    input  in_ready, out_valid, op, func, data_a, data_b, imm, jpc, dst,
           if_reg_write, if_mem_read, if_mem_write, illegal, npc_o, stall_cnt
  );

  modport slave (
    input  in_valid, ins, npc_i, flush, reg_write, write_reg, write_data, out_ready,
    output in_ready, out_valid, op, func, data_a, data_b, imm, jpc, dst,
           if_reg_write, if_mem_read, if_mem_write, illegal, npc_o, stall_cnt
  );
endinterface

// File: rtl/id_pipe_stage.sv
// id_pipe_stage: MIPS instruction decode with a 32-entry register file and a registered
// ID/EX boundary using valid/ready on both sides, flush and a load-use interlock.
// Optional macro ID_WB_BYPASS_EN: a same-cycle writeback to a source register is forwarded
// into the captured operand. When undefined, such a collision blocks capture for one cycle.
module id_pipe_stage #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned STALL_CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  id_pipe_stage_if.slave bus
);

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpJ     = 6'b000010;
  localparam logic [5:0] OpJal   = 6'b000011;
  localparam logic [5:0] OpBeq   = 6'b000100;
  localparam logic [5:0] OpBne   = 6'b000101;
  localparam logic [5:0] OpBgtz  = 6'b000111;
  localparam logic [5:0] OpAddi  = 6'b001000;
  localparam logic [5:0] OpAddiu = 6'b001001;
  localparam logic [5:0] OpAndi  = 6'b001100;
  localparam logic [5:0] OpOri   = 6'b001101;
  localparam logic [5:0] OpXori  = 6'b001110;
  localparam logic [5:0] OpLui   = 6'b001111;
  localparam logic [5:0] OpLb    = 6'b100000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSb    = 6'b101000;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] FnJr    = 6'b001000;

  logic [5:0] opc, fn;
  logic [4:0] rs, rt, rd;

  assign opc = bus.ins[31:26];
  assign rs  = bus.ins[25:21];
  assign rt  = bus.ins[20:16];
  assign rd  = bus.ins[15:11];
  assign fn  = bus.ins[5:0];

  logic [DATA_W-1:0] rf_q [32];

  logic              dec_rw, dec_mr, dec_mw, dec_ill, use_rs, use_rt, zext;
  logic [4:0]        dec_dst;
  logic [DATA_W-1:0] imm_ext, rf_a, rf_b, opnd_a, opnd_b;
  logic              wb_en, wb_hit_a, wb_hit_b, wb_stall, hazard, capture, stall_evt;

  logic                   out_valid_q, out_valid_d;
  logic [5:0]             op_q, func_q;
  logic [DATA_W-1:0]      data_a_q, data_b_q, imm_q;
  logic [25:0]            jpc_q;
  logic [4:0]             dst_q;
  logic                   rw_q, mr_q, mw_q, ill_q;
  logic [31:0]            npc_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Opcode decode: destination, control flags, source usage and extension mode
  always_comb begin
    dec_dst = 5'd0;
    dec_rw  = 1'b0;
    dec_mr  = 1'b0;
    dec_mw  = 1'b0;
    dec_ill = 1'b0;
    use_rs  = 1'b1;
    use_rt  = 1'b0;
    zext    = 1'b0;
    case (opc)
      OpRtype: begin
        use_rt = 1'b1;
        if (fn != FnJr) begin
          dec_rw  = 1'b1;
          dec_dst = rd;
        end
      end
      OpAddi, OpAddiu: begin
        dec_rw  = 1'b1;
        dec_dst = rt;
      end
      OpAndi, OpOri, OpXori: begin
        dec_rw  = 1'b1;
        dec_dst = rt;
        zext    = 1'b1;
      end
      OpLui: begin
        dec_rw  = 1'b1;
        dec_dst = rt;
        use_rs  = 1'b0;
      end
      OpLw, OpLb: begin
        dec_rw  = 1'b1;
        dec_mr  = 1'b1;
        dec_dst = rt;
      end
      OpSw, OpSb: begin
        dec_mw = 1'b1;
        use_rt = 1'b1;
      end
      OpBeq, OpBne: use_rt = 1'b1;
      OpBgtz:       ;
      OpJ:          use_rs = 1'b0;
      OpJal: begin
        use_rs  = 1'b0;
        dec_rw  = 1'b1;
        dec_dst = 5'd31;
      end
      default:      dec_ill = 1'b1;
    endcase
  end

  assign imm_ext = zext ? {{(DATA_W-16){1'b0}}, bus.ins[15:0]}
                        : {{(DATA_W-16){bus.ins[15]}}, bus.ins[15:0]};

  // Operand read with writeback collision handling; R0 always reads zero
  always_comb begin
    rf_a     = (rs == 5'd0) ? '0 : rf_q[rs];
    rf_b     = (rt == 5'd0) ? '0 : rf_q[rt];
    wb_en    = bus.reg_write && (bus.write_reg != 5'd0);
    wb_hit_a = wb_en && (bus.write_reg == rs);
    wb_hit_b = wb_en && (bus.write_reg == rt);
`ifdef ID_WB_BYPASS_EN
    opnd_a   = wb_hit_a ? bus.write_data : rf_a;
    opnd_b   = wb_hit_b ? bus.write_data : rf_b;
    wb_stall = 1'b0;
`else
    opnd_a   = rf_a;
    opnd_b   = rf_b;
    wb_stall = wb_hit_a || wb_hit_b;
`endif
  end

  // Load in ID/EX whose destination feeds a used source of the incoming instruction
  assign hazard = out_valid_q && mr_q && (dst_q != 5'd0) &&
                  ((use_rs && (rs == dst_q)) || (use_rt && (rt == dst_q)));

  assign bus.in_ready = !bus.flush && !hazard && !wb_stall && (!out_valid_q || bus.out_ready);
  assign capture      = bus.in_valid && bus.in_ready;
  assign stall_evt    = bus.in_valid && !bus.flush && (hazard || wb_stall);

  // Next-state for the output valid and the saturating stall counter
  always_comb begin
    out_valid_d = out_valid_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
    end else if (capture) begin
      out_valid_d = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    stall_cnt_d = stall_cnt_q;
    if (stall_evt && !(&stall_cnt_q)) begin
      stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
    end
  end

  // Register file write port, independent of stall and flush
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    end else if (wb_en) begin
      rf_q[bus.write_reg] <= bus.write_data;
    end
  end

  // ID/EX pipeline register; payload loads only on capture, otherwise holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      func_q      <= '0;
      data_a_q    <= '0;
      data_b_q    <= '0;
      imm_q       <= '0;
      jpc_q       <= '0;
      dst_q       <= '0;
      rw_q        <= 1'b0;
      mr_q        <= 1'b0;
      mw_q        <= 1'b0;
      ill_q       <= 1'b0;
      npc_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      stall_cnt_q <= stall_cnt_d;
      if (capture) begin
        op_q     <= opc;
        func_q   <= fn;
        data_a_q <= opnd_a;
        data_b_q <= opnd_b;
        imm_q    <= imm_ext;
        jpc_q    <= bus.ins[25:0];
        dst_q    <= dec_dst;
        rw_q     <= dec_rw;
        mr_q     <= dec_mr;
        mw_q     <= dec_mw;
        ill_q    <= dec_ill;
        npc_q    <= bus.npc_i;
      end
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.op           = op_q;
  assign bus.func         = func_q;
  assign bus.data_a       = data_a_q;
  assign bus.data_b       = data_b_q;
  assign bus.imm          = imm_q;
  assign bus.jpc          = jpc_q;
  assign bus.dst          = dst_q;
  assign bus.if_reg_write = rw_q;
  assign bus.if_mem_read  = mr_q;
  assign bus.if_mem_write = mw_q;
  assign bus.illegal      = ill_q;
  assign bus.npc_o        = npc_q;
  assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_id_pipe_stage.sv
// Scoreboard bench for id_pipe_stage: a behavioural model predicts in_ready, captures and
// the decoded transaction; a monitor compares every transfer on the execute side.
module tb_id_pipe_stage;

  localparam int unsigned DW = 32;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  id_pipe_stage_if #(.DATA_W(DW), .STALL_CNT_W(16)) bus ();
  id_pipe_stage_if #(.DATA_W(64), .STALL_CNT_W(16)) bus64 ();

  id_pipe_stage #(.DATA_W(DW), .STALL_CNT_W(16)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  id_pipe_stage #(.DATA_W(64), .STALL_CNT_W(16)) u_dut64 (
    .clk (clk),
    .rst (rst),
    .bus (bus64)
  );

  typedef struct packed {
    logic [5:0]  op;
    logic [5:0]  func;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
    logic [25:0] jpc;
    logic [4:0]  dst;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        ill;
    logic [31:0] npc;
  } exp_t;

  localparam logic [5:0] OPS [16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h07, 6'h08, 6'h09,
                                      6'h0c, 6'h0d, 6'h0e, 6'h0f, 6'h20, 6'h23, 6'h28, 6'h2b};

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model state: architectural registers and contents of the ID/EX slot
  logic [31:0] regs [32];
  logic        mv;
  logic [4:0]  mdst;
  logic        mmr;
  logic [15:0] mstall;
  exp_t        sb_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) regs[i] = '0;
    mv     = 1'b0;
    mdst   = '0;
    mmr    = 1'b0;
    mstall = '0;
    sb_q.delete();
  endtask

  // Architectural value of a register as seen by an instruction captured this cycle
  function automatic logic [31:0] src_val(input logic [4:0] r, input logic rw,
                                          input logic [4:0] wr, input logic [31:0] wd);
    if (r == 5'd0) return 32'd0;
    if (rw && wr == r) return wd;
    return regs[r];
  endfunction

  function automatic void src_use(input logic [31:0] ins, output logic ur, output logic ut);
    logic [5:0] op;
    op = ins[31:26];
    ur = !(op inside {6'h02, 6'h03, 6'h0f});
    ut = op inside {6'h00, 6'h04, 6'h05, 6'h28, 6'h2b};
  endfunction

  function automatic exp_t model_decode(input logic [31:0] ins, input logic [31:0] npc,
                                        input logic rw, input logic [4:0] wr,
                                        input logic [31:0] wd);
    exp_t       e;
    logic [5:0] op;
    op     = ins[31:26];
    e      = '0;
    e.op   = op;
    e.func = ins[5:0];
    e.jpc  = ins[25:0];
    e.npc  = npc;
    e.a    = src_val(ins[25:21], rw, wr, wd);
    e.b    = src_val(ins[20:16], rw, wr, wd);
    e.imm  = (op inside {6'h0c, 6'h0d, 6'h0e}) ? {16'h0000, ins[15:0]}
                                               : {{16{ins[15]}}, ins[15:0]};
    if (op == 6'h00) begin
      if (ins[5:0] != 6'h08) begin e.rw = 1'b1; e.dst = ins[15:11]; end
    end else if (op inside {6'h08, 6'h09, 6'h0c, 6'h0d, 6'h0e, 6'h0f}) begin
      e.rw = 1'b1; e.dst = ins[20:16];
    end else if (op inside {6'h20, 6'h23}) begin
      e.rw = 1'b1; e.mr = 1'b1; e.dst = ins[20:16];
    end else if (op inside {6'h28, 6'h2b}) begin
      e.mw = 1'b1;
    end else if (op == 6'h03) begin
      e.rw = 1'b1; e.dst = 5'd31;
    end else if (!(op inside {6'h02, 6'h04, 6'h05, 6'h07})) begin
      e.ill = 1'b1;
    end
    return e;
  endfunction

  function automatic logic [31:0] rand_ins();
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd, sh;
    op = ($urandom_range(0, 15) == 0) ? 6'($urandom) : OPS[$urandom_range(0, 15)];
    fn = ($urandom_range(0, 7) == 0) ? 6'h08 : 6'($urandom);
    rs = 5'($urandom_range(0, 7));
    rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 7));
    sh = 5'($urandom);
    return {op, rs, rt, rd, sh, fn};
  endfunction

  // One clock cycle of stimulus plus the model's view of what the stage must do with it
  task automatic cycle(input logic iv, input logic [31:0] ins, input logic fl, input logic rw,
                       input logic [4:0] wr, input logic [31:0] wd, input logic ordy);
    exp_t        e;
    logic        ur, ut, haz, wbs, rdy, cap;
    logic [31:0] npc;
    @(negedge clk);
    chk("out_valid", 64'(bus.out_valid), 64'(mv));
    chk("stall_cnt", 64'(bus.stall_cnt), 64'(mstall));
    npc            = $urandom;
    bus.in_valid   = iv;
    bus.ins        = ins;
    bus.npc_i      = npc;
    bus.flush      = fl;
    bus.reg_write  = rw;
    bus.write_reg  = wr;
    bus.write_data = wd;
    bus.out_ready  = ordy;
    #1;
    src_use(ins, ur, ut);
    haz = mv && mmr && (mdst != 5'd0) &&
          ((ur && ins[25:21] == mdst) || (ut && ins[20:16] == mdst));
    wbs = 1'b0;
`ifndef ID_WB_BYPASS_EN
    wbs = rw && (wr != 5'd0) && (wr == ins[25:21] || wr == ins[20:16]);
`endif
    rdy = !fl && !haz && !wbs && (!mv || ordy);
    chk("in_ready", 64'(bus.in_ready), 64'(rdy));
    cap = iv && rdy;
    e   = model_decode(ins, npc, rw, wr, wd);
    if (cap) sb_q.push_back(e);
    if (iv && !fl && (haz || wbs) && mstall != 16'hffff) mstall++;
    if (fl) mv = 1'b0;
    else if (cap) begin mv = 1'b1; mdst = e.dst; mmr = e.mr; end
    else if (ordy) mv = 1'b0;
    if (rw && wr != 5'd0) regs[wr] = wd;
  endtask

  task automatic idle_inputs();
    bus.in_valid   = 1'b0;
    bus.ins        = '0;
    bus.npc_i      = '0;
    bus.flush      = 1'b0;
    bus.reg_write  = 1'b0;
    bus.write_reg  = '0;
    bus.write_data = '0;
    bus.out_ready  = 1'b0;
  endtask

  // Monitor: every transfer (or flush of a held entry) consumes one expected transaction
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && bus.out_valid && (bus.out_ready || bus.flush)) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          $display("FAIL sb_underflow: got out_valid=1, expected no pending instruction");
        end else begin
          e = sb_q.pop_front();
          if (!bus.flush) begin
            chk("op", 64'(bus.op), 64'(e.op));
            chk("func", 64'(bus.func), 64'(e.func));
            chk("data_a", 64'(bus.data_a), 64'(e.a));
            chk("data_b", 64'(bus.data_b), 64'(e.b));
            chk("imm", 64'(bus.imm), 64'(e.imm));
            chk("jpc", 64'(bus.jpc), 64'(e.jpc));
            chk("dst", 64'(bus.dst), 64'(e.dst));
            chk("if_reg_write", 64'(bus.if_reg_write), 64'(e.rw));
            chk("if_mem_read", 64'(bus.if_mem_read), 64'(e.mr));
            chk("if_mem_write", 64'(bus.if_mem_write), 64'(e.mw));
            chk("illegal", 64'(bus.illegal), 64'(e.ill));
            chk("npc_o", 64'(bus.npc_o), 64'(e.npc));
          end
        end
      end
    end
  end

  initial begin
    idle_inputs();
    bus64.in_valid   = 1'b0;
    bus64.ins        = '0;
    bus64.npc_i      = '0;
    bus64.flush      = 1'b0;
    bus64.reg_write  = 1'b0;
    bus64.write_reg  = '0;
    bus64.write_data = '0;
    bus64.out_ready  = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_data_a", 64'(bus.data_a), 64'd0);
    chk("rst_imm", 64'(bus.imm), 64'd0);
    chk("rst_dst", 64'(bus.dst), 64'd0);
    chk("rst_stall_cnt", 64'(bus.stall_cnt), 64'd0);
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    rst = 1'b1;

    // 64-bit instance: ORI zero-extends to the full width
    bus64.in_valid = 1'b1;
    bus64.ins      = 32'h3402_8000;
    @(negedge clk);
    bus64.in_valid = 1'b0;
    chk("w64_out_valid", 64'(bus64.out_valid), 64'd1);
    chk("w64_ori_imm", bus64.imm, 64'h0000_0000_0000_8000);
    chk("w64_dst", 64'(bus64.dst), 64'd2);

    // Directed: ADDI $1,$0,-1 then ORI 0x8000
    cycle(1'b1, 32'h2001_ffff, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 32'h3402_8000, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    // Writeback $3=0x1234 alongside ADD $4,$3,$3 (held a second cycle for the stalling build)
    cycle(1'b1, 32'h0063_2020, 1'b0, 1'b1, 5'd3, 32'h1234, 1'b1);
    cycle(1'b1, 32'h0063_2020, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    // LW $5 then dependent ADD; then LW $0 with ADD using $0
    cycle(1'b1, 32'h8c05_0000, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    repeat (3) cycle(1'b1, 32'h00a5_3020, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 32'h8c00_0000, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b1, 32'h0000_3020, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    // Backpressure for three cycles, then release
    cycle(1'b1, 32'h2001_ffff, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    repeat (3) cycle(1'b1, 32'h3402_8000, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, 32'h3402_8000, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    // Flush with a held instruction, a new request and a writeback; then read that register
    cycle(1'b1, 32'h2001_ffff, 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    cycle(1'b1, 32'h3402_8000, 1'b1, 1'b1, 5'd7, 32'hcafe, 1'b0);
    cycle(1'b1, 32'h00e0_4020, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);

    // Randomised traffic
    for (int n = 0; n < 1500; n++) begin
      cycle(($urandom_range(0, 3) != 0), rand_ins(), ($urandom_range(0, 15) == 0),
            1'($urandom), 5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset while an instruction is held
    cycle(1'b1, 32'h2001_ffff, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    @(negedge clk);
    chk("pre_rst_valid", 64'(bus.out_valid), 64'(mv));
    idle_inputs();
    #3;
    rst = 1'b0;
    #1;
    chk("async_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("async_rst_stall", 64'(bus.stall_cnt), 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    for (int n = 0; n < 200; n++) begin
      cycle(($urandom_range(0, 3) != 0), rand_ins(), ($urandom_range(0, 15) == 0),
            1'($urandom), 5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 3) != 0));
    end
    cycle(1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1);
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
